// File: rtl/rice_data_ram.sv
// rice_data_ram: single-port, byte-strobed data RAM serving as the slave on the
// core data bus. Writes retire silently. Reads go through a one-cycle RAM stage
// (ram_q / pending_q) into a small in-order response FIFO, so back-to-back reads
// keep flowing while the consumer applies backpressure.
module rice_data_ram #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int RESPONSE_DEPTH = 2   // max outstanding reads, must be >= 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_request_valid,
  output logic              o_request_ready,
  input  logic              i_request_write,
  input  logic [XLEN-1:0]   i_address,
  input  logic [XLEN/8-1:0] i_strobe,
  input  logic [XLEN-1:0]   i_write_data,
  output logic              o_response_valid,
  input  logic              i_response_ready,
  output logic [XLEN-1:0]   o_read_data
);

  localparam int BYTE_SIZE    = XLEN / 8;
  localparam int OFFSET_WIDTH = $clog2(BYTE_SIZE);
  localparam int INDEX_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int WORDS        = 2 ** INDEX_WIDTH;
  localparam int PTR_W        = (RESPONSE_DEPTH > 1) ? $clog2(RESPONSE_DEPTH) : 1;
  localparam int CNT_W        = $clog2(RESPONSE_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] word_index;
  logic                   accept;
  logic                   read_accept;
  logic                   write_accept;
  logic                   run_q;

  // Offset bits and bits above the decoded window are intentionally dropped;
  // addresses alias modulo the RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[XLEN-1:ADDR_WIDTH], i_address[OFFSET_WIDTH-1:0]};

  assign word_index   = i_address[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign accept       = i_request_valid && o_request_ready;
  assign read_accept  = accept && !i_request_write;
  // run_q is low for the first edge after reset release, so a write landing
  // on that edge is dropped instead of corrupting the (non-reset) array.
  assign write_accept = accept && i_request_write && run_q;

  // Arms the write path one edge after reset is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so each lane maps onto its own
  // block RAM with a plain write enable. The read register of each lane has
  // an async reset so o_read_data is 0 out of reset; the array itself is not
  // reset and keeps its contents across reset.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ram_q;

  generate
    for (genvar gi = 0; gi < BYTE_SIZE; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] lane_q;

      // Byte-lane write, enabled by its strobe bit.
      always_ff @(posedge i_clk) begin
        if (write_accept && i_strobe[gi]) begin
          lane_mem[word_index] <= i_write_data[gi*8 +: 8];
        end
      end

      // Registered read, only updated when a read is accepted so the pending
      // word stays stable until it is consumed or moved into the FIFO.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          lane_q <= 8'h00;
        end else if (read_accept) begin
          lane_q <= lane_mem[word_index];
        end
      end

      assign ram_q[gi*8 +: 8] = lane_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response path: pending_q marks a word sitting in ram_q; the FIFO holds
  // older words that the consumer has not taken yet.
  // ---------------------------------------------------------------------------
  logic            pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]  fifo_mem [RESPONSE_DEPTH];

  logic             fifo_empty;
  logic             pop;
  logic             pop_fifo;
  logic             pop_pending;
  logic             push;
  logic [CNT_W:0]   occupancy;

  assign fifo_empty       = (count_q == '0);
  assign o_response_valid = !fifo_empty || pending_q;
  assign o_read_data      = fifo_empty ? ram_q : fifo_mem[rd_ptr_q];

  assign pop         = o_response_valid && i_response_ready;
  assign pop_fifo    = pop && !fifo_empty;
  // With an empty FIFO the consumer takes the pending word straight from ram_q.
  assign pop_pending = pop && fifo_empty;
  // Otherwise the pending word moves to the FIFO tail, freeing ram_q.
  assign push        = pending_q && !pop_pending;

  // Ready depends on registered state only: no path from the request or
  // response handshakes into o_request_ready.
  assign occupancy       = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
  assign o_request_ready = (occupancy < (CNT_W + 1)'(RESPONSE_DEPTH));

  // Next-state for FIFO pointers, occupancy counter and pending flag.
  always_comb begin
    pending_d = read_accept;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    if (push && !pop_fifo) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop_fifo) begin
      count_d = count_q - CNT_W'(1);
    end

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(RESPONSE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_fifo) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RESPONSE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  // Response-path state; reset discards all pending and queued reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // FIFO payload storage; validity is tracked by count_q, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ram_q;
    end
  end

endmodule
